ahb_lite_responder_bridge: RTL

Terminates one responder port of the AHB-Lite interconnect and converts each accepted transfer into a single-outstanding request/acknowledge register access toward a peripheral. It sits at the responder end of the bus: the interconnect drives `hsel` and address/data phases, and this block returns `hreadyout`, `hresp` and `hrdata`. It generates AHB-Lite wait states, the two-cycle ERROR response, byte strobes and a backend timeout.

---
 rtl/ahb_lite_resp_pkg.sv | 26 ++
 rtl/ahb_lite_resp_strb_gen.sv | 28 ++
 rtl/ahb_lite_responder_bridge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ahb_lite_resp_pkg.sv
// Shared types and bus encodings for the AHB-Lite responder bridge.
package ahb_lite_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] trans);
    return !((trans == HTRANS_IDLE) || (trans == HTRANS_BUSY));
  endfunction

endpackage

// File: rtl/ahb_lite_resp_strb_gen.sv
// Byte-strobe generator and size/alignment checker for one address phase.
module ahb_lite_resp_strb_gen #(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [2:0]    i_size,
  input  logic [LB-1:0] i_offset,
  output logic [NB-1:0] o_strb,
  output logic          o_bad
);

  int w_nbytes;
  int w_off;

  assign w_nbytes = 1 << i_size;
  assign w_off    = int'(i_offset);

  // Lanes covered by the transfer, plus oversize or misaligned detection.
  always_comb begin
    o_strb = '0;
    for (int i = 0; i < NB; i++) begin
      o_strb[i] = (i >= w_off) && (i < w_off + w_nbytes);
    end
    o_bad = (i_size > 3'(LB)) || ((w_off & (w_nbytes - 1)) != 0);
  end

endmodule

// File: rtl/ahb_lite_responder_bridge.sv
// AHB-Lite responder that turns each accepted transfer into one
// request/acknowledge access toward a peripheral register port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer in flight, zero-wait OKAY
// CAPTURE | data phase of a good transfer, write data sampled
// ACCESS  | req_o held until ack, error ack or timeout
// RESP    | last data-phase cycle, OKAY, read data on hrdata_o
// ERR1    | first ERROR cycle, hreadyout low
// ERR2    | second ERROR cycle, hreadyout high, may accept next transfer
module ahb_lite_responder_bridge
  import ahb_lite_resp_pkg::*;
#(
  parameter int AHB_LITE_ADDR_WIDTH = 32,
  parameter int AHB_LITE_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic [AHB_LITE_ADDR_WIDTH-1:0]   haddr_i,
  input  logic [AHB_LITE_DATA_WIDTH-1:0]   hwdata_i,
  input  logic                             hsel_i,
  input  logic                             hwrite_i,
  input  logic                             hready_i,
  input  logic [1:0]                       htrans_i,
  input  logic [2:0]                       hsize_i,
  output logic                             hreadyout_o,
  output logic                             hresp_o,
  output logic [AHB_LITE_DATA_WIDTH-1:0]   hrdata_o,
  output logic                             req_o,
  output logic                             req_write_o,
  output logic [AHB_LITE_ADDR_WIDTH-1:0]   req_addr_o,
  output logic [AHB_LITE_DATA_WIDTH-1:0]   req_wdata_o,
  output logic [AHB_LITE_DATA_WIDTH/8-1:0] req_wstrb_o,
  input  logic                             req_ack_i,
  input  logic [AHB_LITE_DATA_WIDTH-1:0]   req_rdata_i,
  input  logic                             req_err_i
);

  localparam int AW = AHB_LITE_ADDR_WIDTH;
  localparam int DW = AHB_LITE_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(NB - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_hreadyout;
  logic            r_hresp;
  logic [DW-1:0]   r_hrdata;
  logic            r_req;
  logic            r_req_write;
  logic [AW-1:0]   r_req_addr;
  logic [DW-1:0]   r_req_wdata;
  logic [NB-1:0]   r_req_wstrb;

  logic            w_accept;
  logic            w_bad;
  logic [NB-1:0]   w_strb;

  assign w_accept = hsel_i & hready_i & htrans_active(htrans_i);

  ahb_lite_resp_strb_gen #(
    .DW (DW)
  ) u_strb_gen (
    .i_size   (hsize_i),
    .i_offset (haddr_i[LB-1:0]),
    .o_strb   (w_strb),
    .o_bad    (w_bad)
  );

  // Transfer sequencing; every bus and backend output is registered here.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_req       <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          if (r_req_write) begin
            r_req_wdata <= hwdata_i;
          end
          r_cnt   <= '0;
          r_req   <= 1'b1;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (req_ack_i) begin
            r_req <= 1'b0;
            if (req_err_i) begin
              r_hresp <= HRESP_ERROR;
              r_state <= ST_ERR1;
            end else begin
              r_hreadyout <= 1'b1;
              r_hrdata    <= r_req_write ? '0 : req_rdata_i;
              r_state     <= ST_RESP;
            end
          end else if (TO_EN && (r_cnt == CNT_LAST)) begin
            r_req   <= 1'b0;
            r_hresp <= HRESP_ERROR;
            r_state <= ST_ERR1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= ST_ERR2;
        end
        default: begin
          // IDLE, RESP and ERR2 all take a new address phase the same way.
          r_hrdata <= '0;
          if (w_accept && w_bad) begin
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_ERROR;
            r_state     <= ST_ERR1;
          end else if (w_accept) begin
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_OKAY;
            r_req_write <= hwrite_i;
            r_req_addr  <= haddr_i & ADDR_MASK;
            r_req_wstrb <= w_strb;
            r_state     <= ST_CAPTURE;
          end else begin
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign hreadyout_o = r_hreadyout;
  assign hresp_o     = r_hresp;
  assign hrdata_o    = r_hrdata;
  assign req_o       = r_req;
  assign req_write_o = r_req_write;
  assign req_addr_o  = r_req_addr;
  assign req_wdata_o = r_req_wdata;
  assign req_wstrb_o = r_req_wstrb;

endmodule
